// File: rtl/coin_vend_ctrl.sv
// Coin-operated vending controller: debounced one-hot switch events drive a
// credit FSM with vend, change-return and reject pulses plus a 3-digit display.
module coin_vend_ctrl #(
  parameter int unsigned NCOIN      = 4,
  parameter int unsigned STEP       = 4,
  parameter int unsigned PRICE      = 12,
  parameter int unsigned MAX_CREDIT = 20,
  parameter int unsigned TICK_W     = 23
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [NCOIN+1:0] SW,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1,
  output logic [0:6]       HEX2,
  output logic             VEND,
  output logic             CHANGE,
  output logic             REJECT,
  output logic             ERR
);

  localparam int unsigned SWW = NCOIN + 2;
  localparam int unsigned CW  = (MAX_CREDIT < 2) ? 1 : $clog2(MAX_CREDIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);

  logic [TICK_W-1:0] cnt_q;
  logic              tick;
  logic [SWW-1:0]    sync1_q, sync2_q, samp_q;
  logic              armed_q, err_q;
  logic              multi, onehot, ev, ev_coin, ev_buy, ev_clr;
  logic [31:0]       coin_val, sum;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              vend_q, vend_d, change_q, change_d, reject_q, reject_d;
  logic [3:0]        dig0, dig1, dig2;
  logic [0:6]        hex0_q, hex1_q, hex2_q;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick   = &cnt_q;
  assign multi  = (sync2_q & (sync2_q - SWW'(1))) != '0;
  assign onehot = (sync2_q != '0) && !multi;
  // armed_q blocks switches still held across reset until an all-zero sample
  assign ev      = tick && armed_q && (samp_q == '0) && onehot;
  assign ev_coin = ev && (sync2_q[NCOIN-1:0] != '0);
  assign ev_buy  = ev && sync2_q[NCOIN];
  assign ev_clr  = ev && sync2_q[NCOIN+1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + TICK_W'(1);
      sync1_q <= SW;
      sync2_q <= sync1_q;
      if (tick) begin
        samp_q <= sync2_q;
        if (sync2_q == '0) begin
          armed_q <= 1'b1;
          err_q   <= 1'b0;
        end else if (multi) begin
          err_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    coin_val = '0;
    for (int unsigned k = 0; k < NCOIN; k++) begin
      if (sync2_q[k]) coin_val = (k + 1) * STEP;
    end
    sum = 32'(credit_q) + coin_val;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = 1'b0;
    change_d = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (ev_coin) begin
          if (sum <= MAX_CREDIT) begin
            credit_d = CW'(sum);
            state_d  = S_HOLD;
          end else begin
            reject_d = 1'b1;
          end
        end else if (ev_buy) begin
          if (state_q == S_HOLD && credit_q >= PRICE_C) begin
            state_d = S_VEND;
            vend_d  = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end else if (ev_clr && state_q == S_HOLD) begin
          state_d = S_RETURN;
        end
      end
      S_VEND: begin
        reject_d = ev;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q == PRICE_C) ? S_IDLE : S_RETURN;
      end
      S_RETURN: begin
        reject_d = ev;
        if (tick) begin
          change_d = 1'b1;
          credit_d = credit_q - STEP_C;
          if (credit_q == STEP_C) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dig0 = 4'(32'(credit_q) % 10);
    dig1 = 4'((32'(credit_q) / 10) % 10);
    dig2 = 4'((32'(credit_q) / 100) % 10);
  end

  // vend_q is raised on entry so it is high exactly for the VEND-state clock
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      hex0_q   <= 7'b0000001;
      hex1_q   <= 7'b0000001;
      hex2_q   <= 7'b0000001;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      reject_q <= reject_d;
      hex0_q   <= seg7(dig0);
      hex1_q   <= seg7(dig1);
      hex2_q   <= seg7(dig2);
    end
  end

  assign HEX0   = hex0_q;
  assign HEX1   = hex1_q;
  assign HEX2   = hex2_q;
  assign VEND   = vend_q;
  assign CHANGE = change_q;
  assign REJECT = reject_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Directed self-checking bench for coin_vend_ctrl with a 4-clock tick.
`timescale 1ns/1ps
module tb_coin_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sw;
  logic [0:6] h0, h1, h2;
  logic       vend, change, reject, err;

  int checks   = 0;
  int failures = 0;
  int vend_n = 0, chg_n = 0, rej_n = 0, both_n = 0;
  longint last_chg = -1;
  longint min_gap  = 1000000;
  int v0, c0, r0;

  always #5 clk = ~clk;

  coin_vend_ctrl #(
    .NCOIN(4), .STEP(4), .PRICE(12), .MAX_CREDIT(20), .TICK_W(2)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw),
    .HEX0(h0), .HEX1(h1), .HEX2(h2),
    .VEND(vend), .CHANGE(change), .REJECT(reject), .ERR(err)
  );

  always @(negedge clk) begin
    if (vend)   vend_n++;
    if (reject) rej_n++;
    if (vend && change) both_n++;
    if (change) begin
      chg_n++;
      if (last_chg >= 0 && ($time - last_chg) < min_gap) min_gap = $time - last_chg;
      last_chg = $time;
    end
  end

  function automatic logic [20:0] hex_exp(input int c);
    logic [0:6] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};
    return {t[(c / 100) % 10], t[(c / 10) % 10], t[c % 10]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] m);
    sw = m;
    ticks(3);
    sw = '0;
    ticks(3);
  endtask

  function automatic logic [20:0] hex_now();
    return {h2, h1, h0};
  endfunction

  initial begin
    sw    = '0;
    rst_n = 1'b0;
    ticks(2);
    check_eq("reset_hex", 32'(hex_now()), 32'(hex_exp(0)));
    check_eq("reset_outs", {28'd0, vend, change, reject, err}, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // coins 4, 8 then BUY
    press(6'b000001);
    check_eq("c4_hex", 32'(hex_now()), 32'(hex_exp(4)));
    press(6'b000010);
    check_eq("c12_hex", 32'(hex_now()), 32'(hex_exp(12)));
    v0 = vend_n; c0 = chg_n;
    press(6'b010000);
    check_eq("buy12_vend", vend_n - v0, 1);
    check_eq("buy12_chg", chg_n - c0, 0);
    check_eq("buy12_hex", 32'(hex_now()), 32'(hex_exp(0)));

    // coins 16, 4 then BUY with 8 change
    press(6'b001000);
    check_eq("c16_hex", 32'(hex_now()), 32'(hex_exp(16)));
    press(6'b000001);
    check_eq("c20_hex", 32'(hex_now()), 32'(hex_exp(20)));
    v0 = vend_n; c0 = chg_n;
    press(6'b010000);
    check_eq("buy20_vend", vend_n - v0, 1);
    check_eq("buy20_chg", chg_n - c0, 2);
    check_eq("buy20_hex", 32'(hex_now()), 32'(hex_exp(0)));

    // ceiling: 16 + 8 refused, 16 + 4 accepted
    press(6'b001000);
    r0 = rej_n;
    press(6'b000010);
    check_eq("over_rej", rej_n - r0, 1);
    check_eq("over_hex", 32'(hex_now()), 32'(hex_exp(16)));
    press(6'b000001);
    check_eq("ceil_hex", 32'(hex_now()), 32'(hex_exp(20)));
    c0 = chg_n;
    press(6'b100000);
    ticks(3);
    check_eq("clr20_chg", chg_n - c0, 5);
    check_eq("clr20_hex", 32'(hex_now()), 32'(hex_exp(0)));

    // two switches together, then a long single hold
    r0 = rej_n;
    sw = 6'b000101;
    ticks(2);
    check_eq("err_set", 32'(err), 32'd1);
    check_eq("err_hex", 32'(hex_now()), 32'(hex_exp(0)));
    sw = '0;
    ticks(2);
    check_eq("err_clr", 32'(err), 32'd0);
    sw = 6'b000001;
    ticks(10);
    sw = '0;
    ticks(3);
    check_eq("hold_once_hex", 32'(hex_now()), 32'(hex_exp(4)));
    check_eq("err_rej", rej_n - r0, 0);

    // credit 12, CLEAR, BUY while returning change
    press(6'b000010);
    check_eq("c12b_hex", 32'(hex_now()), 32'(hex_exp(12)));
    v0 = vend_n; c0 = chg_n; r0 = rej_n;
    sw = 6'b100000; repeat (4) @(negedge clk);
    sw = '0;        repeat (4) @(negedge clk);
    sw = 6'b010000; repeat (4) @(negedge clk);
    sw = '0;
    ticks(4);
    check_eq("ret_rej", rej_n - r0, 1);
    check_eq("ret_vend", vend_n - v0, 0);
    check_eq("ret_chg", chg_n - c0, 3);
    check_eq("ret_hex", 32'(hex_now()), 32'(hex_exp(0)));

    // asynchronous reset in the middle of change return
    press(6'b001000);
    check_eq("c16b_hex", 32'(hex_now()), 32'(hex_exp(16)));
    c0 = chg_n;
    sw = 6'b100000; repeat (4) @(negedge clk);
    sw = '0;        repeat (8) @(negedge clk);
    check_eq("mid_ret_chg", 32'((chg_n - c0 >= 1) && (chg_n - c0 <= 2)), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_hex", 32'(hex_now()), 32'(hex_exp(0)));
    check_eq("arst_outs", {28'd0, vend, change, reject, err}, 32'd0);
    sw = 6'b000001;
    ticks(2);
    rst_n = 1'b1;
    c0 = chg_n;
    ticks(4);
    check_eq("post_rst_chg", chg_n - c0, 0);
    check_eq("held_rst_hex", 32'(hex_now()), 32'(hex_exp(0)));
    sw = '0;
    ticks(3);
    press(6'b000001);
    check_eq("rearm_hex", 32'(hex_now()), 32'(hex_exp(4)));

    check_eq("chg_gap", 32'(min_gap), 32'd40);
    check_eq("vend_chg_overlap", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_vend_ctrl.md
COIN_VEND_CTRL -- requirements
Module: coin_vend_ctrl

Interface
REQ-001 SHALL have parameter NCOIN, default 4, number of coin switches; coin k (0-based) worth (k+1)*STEP.
REQ-002 SHALL have parameter STEP, default 4, credit unit; also the value of one change pulse.
REQ-003 SHALL have parameter PRICE, default 12, item price; legal values are multiples of STEP and at most MAX_CREDIT.
REQ-004 SHALL have parameter MAX_CREDIT, default 20, credit ceiling; legal values are multiples of STEP and at most 999.
REQ-005 SHALL have parameter TICK_W, default 23, tick divider width; one tick every 2^TICK_W clocks.
REQ-006 SHALL have port CLOCK_50, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port RESET_N, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port SW, input, NCOIN+2, [NCOIN-1:0] coins, [NCOIN] BUY, [NCOIN+1] CLEAR; asynchronous inputs.
REQ-009 SHALL have ports HEX0, HEX1, HEX2, output, [0:6] each, active-low 7-seg (index 0 = seg a ... 6 = seg g), credit units/tens/hundreds.
REQ-010 SHALL have port VEND, output, 1, one-clock pulse per item dispensed.
REQ-011 SHALL have port CHANGE, output, 1, one-clock pulse per STEP of change returned.
REQ-012 SHALL have port REJECT, output, 1, one-clock pulse per refused request.
REQ-013 SHALL have port ERR, output, 1, level: more than one switch held.

Function
REQ-014 SHALL synchronise SW through two flops, then sample it on tick only (debounce); tick = one-clock enable when the TICK_W-bit free-running counter wraps to 0.
REQ-015 SHALL raise an event on a tick whose sample is exactly one-hot while the previous tick's sample was all-zero; held switches produce no further events.
REQ-016 SHALL set ERR on any tick whose sample has more than one bit set; no event is generated; ERR clears on the first all-zero sample.
REQ-017 SHALL hold credit in ceil(log2(MAX_CREDIT+1)) bits; credit is always a multiple of STEP and within 0..MAX_CREDIT.
REQ-018 SHALL implement FSM states IDLE (credit 0), HOLD (credit>0), VEND, RETURN.
REQ-019 SHALL, on coin event k in IDLE/HOLD: if credit+(k+1)*STEP <= MAX_CREDIT, add it and enter HOLD; else leave credit unchanged and pulse REJECT.
REQ-020 SHALL, on BUY event in HOLD with credit >= PRICE, enter VEND; in VEND for exactly one clock, VEND=1, credit -= PRICE, then enter RETURN (or IDLE if credit now 0).
REQ-021 SHALL, on BUY event with credit < PRICE (including IDLE), pulse REJECT and stay.
REQ-022 SHALL, on CLEAR event in HOLD, enter RETURN; CLEAR in IDLE is a no-op.
REQ-023 SHALL, in RETURN, on each tick pulse CHANGE for one clock and subtract STEP; enter IDLE when credit reaches 0.
REQ-024 SHALL ignore coin/BUY/CLEAR events in VEND/RETURN except to pulse REJECT for each one.
REQ-025 SHALL register HEX outputs from binary-to-BCD of credit; HEX reflects credit one clock after credit changes; leading zeros shown (0 = 0000001 on each digit).
REQ-026 SHALL never assert VEND and CHANGE in the same clock.

Reset
REQ-027 SHALL, while RESET_N=0 (at any time, mid-VEND/RETURN included): credit=0, FSM=IDLE, tick counter=0, sync/sample flops=0, VEND=CHANGE=REJECT=ERR=0, HEX0..2=0000001; no refund of lost credit.
REQ-028 SHALL treat switches held when RESET_N rises as new events only after an all-zero sample.

Verification (TICK_W=2 in simulation)
REQ-029 Coins 4,8 then BUY (PRICE 12) -> credit 4,12; VEND pulse once; credit 0; IDLE; HEX=000; no CHANGE.
REQ-030 Coins 16,4 then BUY -> VEND once, then exactly 2 CHANGE pulses one tick apart, credit 8->4->0, HEX 020,008,004,000.
REQ-031 Credit 16, insert 8 -> REJECT one clock, credit stays 16; insert 4 -> credit 20 (saturation boundary accepted).
REQ-032 SW[0] and SW[2] held together -> ERR=1, credit unchanged; release -> ERR=0 on next tick; single press then counts once despite 10-tick hold.
REQ-033 Credit 12, CLEAR -> 3 CHANGE pulses, IDLE; BUY during RETURN -> REJECT, no VEND.
REQ-034 RESET_N low mid-RETURN -> all outputs at reset values immediately (asynchronously), HEX=000, no further CHANGE after release.
